// File: rtl/msrh_lsu_pkg.sv
// ---------------------------------------------------------------------------
// msrh_lsu_pkg
//   Shared LSU types and defaults used by the L1D read-port arbiter.
//   - l1d_arb_status_t : s1 response status returned to a requester
//   - L1D_ARB_*_DEFAULT : default parameter values for the arbiter
// ---------------------------------------------------------------------------
package msrh_lsu_pkg;

  // Default widths used when the core configuration packages are not in scope.
  localparam int L1D_ARB_PADDR_W_DEFAULT    = 56;
  localparam int L1D_ARB_DATA_W_DEFAULT     = 128;
  localparam int L1D_ARB_STARVE_MAX_DEFAULT = 7;

  typedef enum logic [1:0] {
    L1D_ARB_NONE     = 2'd0,
    L1D_ARB_HIT      = 2'd1,
    L1D_ARB_MISS     = 2'd2,
    L1D_ARB_CONFLICT = 2'd3
  } l1d_arb_status_t;

endpackage

// File: rtl/msrh_rr_picker.sv
// ---------------------------------------------------------------------------
// msrh_rr_picker
//   Round-robin picker: returns the first set bit of i_req found when scanning
//   upward from index i_ptr, wrapping at WIDTH. Purely combinational.
//   Ports:
//     i_req  [WIDTH]  request vector
//     i_ptr  [PTR_W]  index with highest priority this cycle
//     o_pick [WIDTH]  one-hot pick, all zero when i_req is zero
// ---------------------------------------------------------------------------
module msrh_rr_picker #(
  parameter int WIDTH = 4,
  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [WIDTH-1:0] o_pick
);

  logic [2*WIDTH-1:0] req_dbl;
  logic [WIDTH-1:0]   req_rot;
  logic [WIDTH-1:0]   pick_rot;
  logic [2*WIDTH-1:0] pick_dbl;

  // Rotate so i_ptr lands on bit 0, take the lowest set bit, rotate back.
  assign req_dbl  = {i_req, i_req} >> i_ptr;
  assign req_rot  = req_dbl[WIDTH-1:0];
  assign pick_rot = req_rot & (-req_rot);
  assign pick_dbl = {pick_rot, pick_rot} << i_ptr;
  assign o_pick   = pick_dbl[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/msrh_l1d_rd_arbiter.sv
// ---------------------------------------------------------------------------
// msrh_l1d_rd_arbiter
//   Shares one L1D read port (s0 request / s1 response) among REQ_NUM
//   requesters. s0 grant order: starving requester (lowest index), then
//   high-priority requesters round-robin, then normal requesters round-robin.
//   The s1 response is routed to the requester granted one cycle earlier.
//   Ports:
//     i_clk, i_reset_n           clock, synchronous active-low reset
//     i_req_valid/h_pri/paddr    per-requester s0 request
//     o_grant                    one-hot s0 grant (same cycle)
//     i_dc_s0_block              dcache cannot accept a read this cycle
//     o_dc_s0_valid/paddr        s0 request to dcache
//     i_dc_s1_hit/miss/conflict  dcache s1 result
//     i_dc_s1_data               dcache s1 data
//     i_s1_kill                  per-requester s1 response drop
//     o_s1_valid/status/data     s1 response to requesters
// ---------------------------------------------------------------------------
module msrh_l1d_rd_arbiter
  import msrh_lsu_pkg::*;
#(
  parameter int REQ_NUM    = 4,
  parameter int PADDR_W    = L1D_ARB_PADDR_W_DEFAULT,
  parameter int DATA_W     = L1D_ARB_DATA_W_DEFAULT,
  parameter int STARVE_MAX = L1D_ARB_STARVE_MAX_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [REQ_NUM-1:0]         i_req_valid,
  input  logic [REQ_NUM-1:0]         i_req_h_pri,
  input  logic [REQ_NUM*PADDR_W-1:0] i_req_paddr,
  output logic [REQ_NUM-1:0]         o_grant,
  input  logic                       i_dc_s0_block,
  output logic                       o_dc_s0_valid,
  output logic [PADDR_W-1:0]         o_dc_s0_paddr,
  input  logic                       i_dc_s1_hit,
  input  logic                       i_dc_s1_miss,
  input  logic                       i_dc_s1_conflict,
  input  logic [DATA_W-1:0]          i_dc_s1_data,
  input  logic [REQ_NUM-1:0]         i_s1_kill,
  output logic [REQ_NUM-1:0]         o_s1_valid,
  output l1d_arb_status_t            o_s1_status,
  output logic [DATA_W-1:0]          o_s1_data
);

  localparam int PTR_W = $clog2(REQ_NUM);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(REQ_NUM - 1);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   starve_cnt_q [REQ_NUM];
  logic [CNT_W-1:0]   starve_cnt_d [REQ_NUM];
  logic [REQ_NUM-1:0] s1_grant_q, s1_grant_d;

  logic [REQ_NUM-1:0] starving;
  logic [REQ_NUM-1:0] hpri_req;
  logic [REQ_NUM-1:0] hpri_pick;
  logic [REQ_NUM-1:0] norm_pick;
  logic [REQ_NUM-1:0] grant_sel;
  logic [PTR_W-1:0]   grant_idx;

  assign hpri_req = i_req_valid & i_req_h_pri;

  msrh_rr_picker #(.WIDTH(REQ_NUM)) u_hpri_picker (
    .i_req  (hpri_req),
    .i_ptr  (rr_ptr_q),
    .o_pick (hpri_pick)
  );

  msrh_rr_picker #(.WIDTH(REQ_NUM)) u_norm_picker (
    .i_req  (i_req_valid),
    .i_ptr  (rr_ptr_q),
    .o_pick (norm_pick)
  );

  // s0 arbitration
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    grant_sel = norm_pick;
    for (int k = 0; k < REQ_NUM; k++) begin
      starving[k] = i_req_valid[k] && (starve_cnt_q[k] == CNT_MAX);
    end
    if (|starving) begin
      grant_sel = starving & (-starving);   // lowest-index starving requester
    end else if (|hpri_req) begin
      grant_sel = hpri_pick;
    end
    o_grant = i_dc_s0_block ? '0 : grant_sel;
  end

  assign o_dc_s0_valid = |o_grant;

  // Address mux and grant index encode (o_grant is one-hot or zero).
  always_comb begin
    o_dc_s0_paddr = '0;
    grant_idx     = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (o_grant[k]) begin
        o_dc_s0_paddr = i_req_paddr[k*PADDR_W +: PADDR_W];
        grant_idx     = PTR_W'(k);
      end
    end
  end

  // Next-state: pointer, starvation counters, s1 routing.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (o_dc_s0_valid) begin
      rr_ptr_d = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
    end
    for (int k = 0; k < REQ_NUM; k++) begin
      // Blocked cycles count as denied; a dropped request clears the count.
      if (i_req_valid[k] && !o_grant[k]) begin
        starve_cnt_d[k] = (starve_cnt_q[k] == CNT_MAX) ? CNT_MAX : starve_cnt_q[k] + 1'b1;
      end else begin
        starve_cnt_d[k] = '0;
      end
    end
    s1_grant_d = o_grant;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!i_reset_n) begin
      rr_ptr_q     <= '0;
      starve_cnt_q <= '{default: '0};
      s1_grant_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      s1_grant_q   <= s1_grant_d;
    end
  end

  // s1 response
  assign o_s1_valid = s1_grant_q & ~i_s1_kill;
  assign o_s1_data  = i_dc_s1_data;

  always_comb begin
    o_s1_status = L1D_ARB_NONE;
    if (|o_s1_valid) begin
      if      (i_dc_s1_conflict) o_s1_status = L1D_ARB_CONFLICT;
      else if (i_dc_s1_hit)      o_s1_status = L1D_ARB_HIT;
      else if (i_dc_s1_miss)     o_s1_status = L1D_ARB_MISS;
    end
  end

  a_s1_grant_onehot : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $onehot0(s1_grant_q))
    else $fatal(1, "s1 grant vector is not one-hot: %b", s1_grant_q);

endmodule

// File: doc/msrh_l1d_rd_arbiter.md
Name: msrh_l1d_rd_arbiter

Overview:
- Shares one L1D read port (s0 request / s1 response) among REQ_NUM requesters, e.g. PTW, snoop, store buffer and miss-unit replays.
- Fixes the arbitration, which the top level currently does with static port numbering.
- s0 grant order: starvation override, then high-priority requesters round-robin, then normal requesters round-robin.
- Routes the s1 response back to the requester granted one cycle earlier, with per-requester kill.

Parameters:
REQ_NUM, 4, number of requesters (>=2)
PADDR_W, riscv_pkg::PADDR_W, physical address width
DATA_W, msrh_conf_pkg::DCACHE_DATA_W, L1D read data width
STARVE_MAX, 7, denied-request cycles before forced grant (>=1)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_req_valid  in  REQ_NUM  per-requester s0 request
i_req_h_pri  in  REQ_NUM  per-requester high-priority flag
i_req_paddr  in  REQ_NUM*PADDR_W  packed s0 addresses, requester k at [k*PADDR_W +: PADDR_W]
o_grant  out  REQ_NUM  one-hot s0 grant, same cycle
i_dc_s0_block  in  1  dcache cannot accept reads this cycle
o_dc_s0_valid  out  1  to dcache s0_valid
o_dc_s0_paddr  out  PADDR_W  to dcache s0_paddr
i_dc_s1_hit / i_dc_s1_miss / i_dc_s1_conflict  in  1 each  dcache s1 result
i_dc_s1_data  in  DATA_W  dcache s1 data
i_s1_kill  in  REQ_NUM  drop the s1 response for requester k
o_s1_valid  out  REQ_NUM  one-hot s1 response valid
o_s1_status  out  2  l1d_arb_status_t
o_s1_data  out  DATA_W  pass-through of i_dc_s1_data

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset_n is synchronous, active-low; every flop is cleared on the rising i_clk edge while i_reset_n=0.
- Reset values:
  - r_rr_ptr=0, r_starve_cnt[*]=0, r_s1_grant=0.
  - Outputs are combinational from these or from inputs; o_s1_valid=0 out of reset.
- s0 grant, combinational:
  - i_dc_s0_block=1 forces o_grant=0.
  - Otherwise:
    - If any valid requester has r_starve_cnt==STARVE_MAX, grant the lowest-index such requester.
    - Else, if any valid requester has h_pri=1, grant round-robin among those, starting at r_rr_ptr.
    - Else grant round-robin among valid requesters, starting at r_rr_ptr.
  - o_dc_s0_valid = |o_grant.
  - o_dc_s0_paddr = paddr of the granted requester; 0 when no grant.
- Round-robin pointer: on any grant, r_rr_ptr <= (granted_idx+1) mod REQ_NUM. Wrap from REQ_NUM-1 to 0. Unchanged when there is no grant.
- Starvation counters, per requester k:
  - valid & ~grant -> cnt+1, saturating at STARVE_MAX.
  - granted or not valid -> 0.
  - Blocked cycles also count.
- s1:
  - r_s1_grant <= o_grant every cycle; reset clears it.
  - o_s1_valid = r_s1_grant & ~i_s1_kill.
- o_s1_status priority: conflict(2'b11) > hit(2'b01) > miss(2'b10) > none(2'b00). Valid only where o_s1_valid is set.
- o_s1_data is driven unconditionally.
- Latency: grant in cycle N, response in N+1. Back-to-back grants are allowed every cycle.
- Simultaneous events:
  - A requester may re-request in the same cycle it receives its s1 response.
  - A kill on a requester without an outstanding response has no effect.
  - Several starving requesters: lowest index first; the others keep saturating until granted.
- Reset mid-operation: an in-flight s1 response is dropped, with no o_s1_valid after reset.
- Requester contract:
  - Hold the request until granted; a dropped request resets its counter.
  - A non-one-hot r_s1_grant is illegal; the SIMULATION assertion fires ($fatal).

Decomposition:
- Package msrh_lsu_pkg gains:
  - typedef l1d_arb_status_t, 2-bit enum: L1D_ARB_NONE=0, L1D_ARB_HIT=1, L1D_ARB_MISS=2, L1D_ARB_CONFLICT=3.
  - localparam L1D_ARB_STARVE_MAX_DEFAULT=7.
- Sub-module msrh_rr_picker (params WIDTH):
  - Inputs: request vector and pointer.
  - Output: one-hot pick.
  - Instantiated twice, for the h_pri and normal classes.

Test Plan:
- REQ_NUM=4, all four requesting, no h_pri, continuous for 8 cycles -> grants 0,1,2,3,0,1,2,3. o_s1_valid follows one cycle later; r_rr_ptr wraps 3->0.
- Req0 h_pri=1 and req1/req2 normal, held 9 cycles, STARVE_MAX=7:
  - grants go to req0 for cycles 0-6.
  - req1 reaches cnt=7 and is granted in cycle 7.
  - req2, also at cnt=7 after req1's grant, is granted in cycle 8.
  - req1 cnt resets to 0.
- i_dc_s0_block=1 for 3 cycles with req3 valid -> o_grant=0, o_dc_s0_valid=0, req3 cnt=3. Req3 is granted on the first unblocked cycle.
- Grant req2 at cycle N, i_dc_s1_hit=1 and i_dc_s1_conflict=1 at N+1 -> o_s1_valid=4'b0100, o_s1_status=2'b11.
- Grant req1 at cycle N, i_s1_kill=4'b0010 at N+1 -> o_s1_valid=0. A kill of req0 instead leaves o_s1_valid=4'b0010.
- Grant req0 at N, i_reset_n=0 at N+1 -> o_s1_valid=0 at N+2; pointer and counters are 0 after reset.
